alu_share_arbiter: RTL

ALU_SHARE_ARBITER -- requirements
Module: alu_share_arbiter

---
 rtl/alu_share_arbiter.sv | 130 +++++++++++++
 1 files changed

// File: rtl/alu_share_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : alu_share_arbiter
// Description : Two-requester arbiter that shares one combinational ALU via
//               an IDLE/EXEC/RESP handshake. Optional macro ALU_ARB_RR_EN
//               enables round-robin contention resolution (default: req 0 wins).
// Revision    : 1.0 - initial release
// ============================================================================
module alu_share_arbiter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [1:0]       req_valid,
  output logic [1:0]       req_ready,
  input  logic [2:0]       req0_ctl,
  input  logic [2:0]       req1_ctl,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  output logic [2:0]       alu_ctl,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  input  logic [WIDTH-1:0] alu_y,
  input  logic             alu_zero,
  output logic [1:0]       rsp_valid,
  input  logic [1:0]       rsp_ready,
  output logic [WIDTH-1:0] rsp_data,
  output logic             rsp_zero,
  output logic             busy
);

  localparam logic [1:0] c_idle = 2'd0;
  localparam logic [1:0] c_exec = 2'd1;
  localparam logic [1:0] c_resp = 2'd2;
  localparam logic [2:0] c_ctl_rst = 3'b010;

  logic [1:0]       r_state;
  logic             r_winner;
  logic [2:0]       r_alu_ctl;
  logic [WIDTH-1:0] r_alu_a;
  logic [WIDTH-1:0] r_alu_b;
  logic [1:0]       r_rsp_valid;
  logic [WIDTH-1:0] r_rsp_data;
  logic             r_rsp_zero;

  logic w_ptr;
  logic w_grant;
  logic w_accept;
  logic w_rsp_done;

`ifdef ALU_ARB_RR_EN
  logic r_ptr;

  // After each served response, the requester that was not served gets priority.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ptr <= 1'b0;
    end else if (w_rsp_done) begin
      r_ptr <= ~r_winner;
    end
  end

  assign w_ptr = r_ptr;
`else
  assign w_ptr = 1'b0;
`endif

  always_comb begin
    w_grant = 1'b0;
    case (req_valid)
      2'b10:   w_grant = 1'b1;
      2'b11:   w_grant = w_ptr;
      default: w_grant = 1'b0;
    endcase
  end

  assign w_accept   = (r_state == c_idle) && (req_valid != 2'b00);
  assign w_rsp_done = (r_state == c_resp) && rsp_ready[r_winner];
  assign req_ready  = w_accept ? (w_grant ? 2'b10 : 2'b01) : 2'b00;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= c_idle;
      r_winner    <= 1'b0;
      r_alu_ctl   <= c_ctl_rst;
      r_alu_a     <= '0;
      r_alu_b     <= '0;
      r_rsp_valid <= 2'b00;
      r_rsp_data  <= '0;
      r_rsp_zero  <= 1'b0;
    end else begin
      case (r_state)
        c_idle: begin
          if (w_accept) begin
            r_state   <= c_exec;
            r_winner  <= w_grant;
            r_alu_ctl <= w_grant ? req1_ctl : req0_ctl;
            r_alu_a   <= w_grant ? req1_a   : req0_a;
            r_alu_b   <= w_grant ? req1_b   : req0_b;
          end
        end
        c_exec: begin
          r_rsp_data  <= alu_y;
          r_rsp_zero  <= alu_zero;
          r_rsp_valid <= r_winner ? 2'b10 : 2'b01;
          r_state     <= c_resp;
        end
        c_resp: begin
          if (w_rsp_done) begin
            r_rsp_valid <= 2'b00;
            r_state     <= c_idle;
          end
        end
        default: r_state <= c_idle;
      endcase
    end
  end

  assign alu_ctl   = r_alu_ctl;
  assign alu_a     = r_alu_a;
  assign alu_b     = r_alu_b;
  assign rsp_valid = r_rsp_valid;
  assign rsp_data  = r_rsp_data;
  assign rsp_zero  = r_rsp_zero;
  assign busy      = (r_state != c_idle);

endmodule
`default_nettype wire
